imem_loader: RTL

- Writer side of the instruction-memory interface: the core only fetches from instruction memory, and this block is what fills it.
- Accepts a byte stream (valid/ready), frames it as length + little-endian words + checksum, and issues one word write per 4 bytes.
- Holds the core in reset (cpu_hold) until a complete, checksum-verified image is loaded.
- Sits between a UART/debug byte source and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame layout.
package imem_loader_pkg;

    localparam logic [2:0] ST_LEN   = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_CSUM  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts accepted bytes into a little-endian 32-bit word; flags the 4th byte.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [31:0] shift_q;
    logic [1:0]  count_q;

    // The completed word is visible combinationally while its last byte is accepted,
    // so the owner can latch it on the same edge.
    assign word          = {byte_data, shift_q[31:8]};
    assign word_complete = byte_valid && (count_q == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (byte_valid) begin
            shift_q <= word;
            count_q <= count_q + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory: length, LE words, XOR checksum.
// Handshake: a byte moves when in_valid && in_ready; in_ready depends only on state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic [2:0]  dbg_state
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    logic [2:0]       state_q;
    logic [31:0]      len_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       csum_q;

    logic        accept;
    logic        pack_valid;
    logic        do_reload;
    logic        last_word;
    logic [31:0] pk_word;
    logic        pk_complete;
    logic [31:0] idx_addr;

    assign in_ready  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign cpu_hold  = (state_q != ST_DONE);
    assign dbg_state = state_q;

    assign accept     = in_valid && in_ready;
    assign pack_valid = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));
    assign do_reload  = reload && ((state_q == ST_DONE) || (state_q == ST_ERROR));
    assign last_word  = (32'(idx_q) == (len_q - 32'd1));
    assign idx_addr   = BASE_ADDR + (32'(idx_q) << 2);

    imem_loader_byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (do_reload),
        .byte_valid    (pack_valid),
        .byte_data     (in_data),
        .word          (pk_word),
        .word_complete (pk_complete)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LEN;
            len_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state_q)
                ST_LEN: begin
                    if (pk_complete) begin
                        len_q <= pk_word;
                        // Full 32-bit compare: upper length bits must not be dropped.
                        if (pk_word > 32'(DEPTH)) begin
                            state_q <= ST_ERROR;
                        end else if (pk_word == 32'd0) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        csum_q <= csum_q ^ in_data;
                    end
                    if (pk_complete) begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= pk_word;
                        mem_addr     <= idx_addr;
                        words_loaded <= words_loaded + 16'd1;
                        if (last_word) begin
                            state_q <= ST_CSUM;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        state_q <= (in_data == csum_q) ? ST_DONE : ST_ERROR;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (do_reload) begin
                        state_q      <= ST_LEN;
                        len_q        <= '0;
                        idx_q        <= '0;
                        csum_q       <= '0;
                        mem_addr     <= BASE_ADDR;
                        words_loaded <= '0;
                    end
                end
                default: begin
                    state_q <= ST_LEN;
                end
            endcase
        end
    end

endmodule
